// File: rtl/ysyx_23060332_ifu_if.sv
// Fetch-unit bus: the instruction-memory request/response channel, the IDU
// instruction handshake and the EXU redirect.
interface ysyx_23060332_ifu_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        misalign_err;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_o, pc_o, misalign_err,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready, jump_en, jump_addr
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_o, pc_o, misalign_err,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready, jump_en, jump_addr
  );
endinterface

// File: rtl/ysyx_23060332_ifu.sv
// Single-outstanding instruction fetch unit: IDLE -> REQ -> WAIT -> HOLD -> REQ.
// Define YSYX_23060332_IFU_MISALIGN_CHK_EN to halt on a misaligned redirect.
module ysyx_23060332_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic                        clk,
  input  logic                        rst,
  ysyx_23060332_ifu_if.master         bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    HALT = 3'd4
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] inst_reg, inst_next;
  logic        retire;
  logic [31:0] target;

  assign retire = (state_reg == HOLD) && bus.inst_ready;
  // Redirect targets are word aligned; the low bits are discarded.
  assign target = bus.jump_addr & 32'hFFFF_FFFC;

`ifdef YSYX_23060332_IFU_MISALIGN_CHK_EN
  logic misalign_reg, misalign_next;
  logic bad_jump;

  assign bad_jump = bus.jump_en && (bus.jump_addr[1:0] != 2'b00);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
      inst_reg  <= 32'h0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      inst_reg  <= inst_next;
    end
  end

`ifdef YSYX_23060332_IFU_MISALIGN_CHK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_reg <= 1'b0;
    end else begin
      misalign_reg <= misalign_next;
    end
  end
`endif

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    inst_next  = inst_reg;
`ifdef YSYX_23060332_IFU_MISALIGN_CHK_EN
    misalign_next = misalign_reg;
`endif
    case (state_reg)
      IDLE: state_next = REQ;
      REQ: begin
        if (bus.imem_req_ready) state_next = WAIT;
      end
      WAIT: begin
        if (bus.imem_rsp_valid) begin
          inst_next  = bus.imem_rsp_data;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (retire) begin
`ifdef YSYX_23060332_IFU_MISALIGN_CHK_EN
          if (bad_jump) begin
            misalign_next = 1'b1;
            state_next    = HALT;
          end else begin
            pc_next    = bus.jump_en ? target : pc_reg + 32'd4;
            state_next = REQ;
          end
`else
          pc_next    = bus.jump_en ? target : pc_reg + 32'd4;
          state_next = REQ;
`endif
        end
      end
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  assign bus.imem_req_valid = (state_reg == REQ);
  assign bus.imem_req_addr  = pc_reg;
  assign bus.inst_valid     = (state_reg == HOLD);
  assign bus.inst_o         = inst_reg;
  assign bus.pc_o           = pc_reg;
`ifdef YSYX_23060332_IFU_MISALIGN_CHK_EN
  assign bus.misalign_err   = misalign_reg;
`else
  assign bus.misalign_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// Directed cycle-by-cycle vectors for the fetch unit, plus a misaligned
// redirect sequence whose expectation follows the build configuration.
module tb_ysyx_23060332_ifu;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  ysyx_23060332_ifu_if bus ();

  ysyx_23060332_ifu #(.RESET_PC(32'h8000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        inst_ready;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        e_req_valid;
    logic        e_inst_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic rr, input logic rv,
                              input logic [31:0] rd, input logic ir, input logic je,
                              input logic [31:0] ja, input logic erv, input logic eiv,
                              input logic [31:0] epc, input logic [31:0] einst);
    vec_t v;
    v.rst = r; v.req_ready = rr; v.rsp_valid = rv; v.rsp_data = rd;
    v.inst_ready = ir; v.jump_en = je; v.jump_addr = ja;
    v.e_req_valid = erv; v.e_inst_valid = eiv; v.e_pc = epc; v.e_inst = einst;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rr, input logic rv, input logic [31:0] rd,
                       input logic ir, input logic je, input logic [31:0] ja);
    rst = r;
    bus.imem_req_ready = rr;
    bus.imem_rsp_valid = rv;
    bus.imem_rsp_data  = rd;
    bus.inst_ready     = ir;
    bus.jump_en        = je;
    bus.jump_addr      = ja;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic erv, input logic eiv,
                               input logic [31:0] epc, input logic [31:0] einst,
                               input logic emis);
    check({tag, ".req_valid"},  {31'b0, bus.imem_req_valid}, {31'b0, erv});
    check({tag, ".inst_valid"}, {31'b0, bus.inst_valid},     {31'b0, eiv});
    check({tag, ".pc"},         bus.pc_o,                    epc);
    check({tag, ".req_addr"},   bus.imem_req_addr,           epc);
    check({tag, ".inst"},       bus.inst_o,                  einst);
    check({tag, ".misalign"},   {31'b0, bus.misalign_err},   {31'b0, emis});
  endtask

  localparam logic [31:0] DB = 32'hDEAD_BEEF;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 32'h0;
    bus.inst_ready = 1'b0; bus.jump_en = 1'b0; bus.jump_addr = 32'h0;

    //           rst rr rv data          ir je addr           erv eiv pc             inst
    vecs.push_back(mk(1, 1, 1, DB,           1, 1, 32'h0000_0040, 0, 0, 32'h8000_0000, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,             1, 0, 32'h8000_0000, 32'h0));
    vecs.push_back(mk(0, 1, 1, DB,           0, 1, 32'h0000_0040, 0, 0, 32'h8000_0000, 32'h0));
    vecs.push_back(mk(0, 0, 1, 32'h0000_0413, 0, 0, 0,            0, 1, 32'h8000_0000, 32'h0000_0413));
    vecs.push_back(mk(0, 0, 0, 0,            1, 0, 0,             1, 0, 32'h8000_0004, 32'h0000_0413));
    vecs.push_back(mk(0, 0, 1, DB,           0, 1, 32'h0000_0200, 1, 0, 32'h8000_0004, 32'h0000_0413));
    vecs.push_back(mk(0, 0, 0, 0,            1, 0, 0,             1, 0, 32'h8000_0004, 32'h0000_0413));
    vecs.push_back(mk(0, 0, 1, DB,           0, 0, 0,             1, 0, 32'h8000_0004, 32'h0000_0413));
    vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,             1, 0, 32'h8000_0004, 32'h0000_0413));
    vecs.push_back(mk(0, 1, 0, 0,            0, 1, 32'h0000_0300, 0, 0, 32'h8000_0004, 32'h0000_0413));
    vecs.push_back(mk(0, 0, 1, 32'h0010_0093, 0, 0, 0,            0, 1, 32'h8000_0004, 32'h0010_0093));
    vecs.push_back(mk(0, 0, 1, DB,           0, 1, 32'h1234_5678, 0, 1, 32'h8000_0004, 32'h0010_0093));
    vecs.push_back(mk(0, 0, 0, 0,            0, 0, 32'h1234_5678, 0, 1, 32'h8000_0004, 32'h0010_0093));
    vecs.push_back(mk(0, 0, 1, DB,           0, 1, 32'h1234_5678, 0, 1, 32'h8000_0004, 32'h0010_0093));
    vecs.push_back(mk(0, 0, 0, 0,            1, 1, 32'h8000_0100, 1, 0, 32'h8000_0100, 32'h0010_0093));
    vecs.push_back(mk(0, 1, 0, 0,            0, 0, 0,             0, 0, 32'h8000_0100, 32'h0010_0093));
    vecs.push_back(mk(0, 0, 0, 0,            1, 1, 32'h0000_0500, 0, 0, 32'h8000_0100, 32'h0010_0093));
    vecs.push_back(mk(0, 0, 1, 32'hFFF0_0113, 0, 0, 0,            0, 1, 32'h8000_0100, 32'hFFF0_0113));
    vecs.push_back(mk(0, 0, 0, 0,            1, 1, 32'hFFFF_FFFC, 1, 0, 32'hFFFF_FFFC, 32'hFFF0_0113));
    vecs.push_back(mk(0, 1, 0, 0,            0, 0, 0,             0, 0, 32'hFFFF_FFFC, 32'hFFF0_0113));
    vecs.push_back(mk(0, 0, 1, 32'h0000_0011, 0, 0, 0,            0, 1, 32'hFFFF_FFFC, 32'h0000_0011));
    vecs.push_back(mk(0, 0, 0, 0,            1, 0, 0,             1, 0, 32'h0000_0000, 32'h0000_0011));
    vecs.push_back(mk(0, 1, 0, 0,            0, 0, 0,             0, 0, 32'h0000_0000, 32'h0000_0011));
    vecs.push_back(mk(1, 1, 1, DB,           1, 1, 32'h0000_0700, 0, 0, 32'h8000_0000, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,             1, 0, 32'h8000_0000, 32'h0));

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].req_ready, vecs[i].rsp_valid, vecs[i].rsp_data,
            vecs[i].inst_ready, vecs[i].jump_en, vecs[i].jump_addr);
      check_outputs($sformatf("vec%0d", i), vecs[i].e_req_valid, vecs[i].e_inst_valid,
                    vecs[i].e_pc, vecs[i].e_inst, 1'b0);
      $display("[TB] vec %0d: req_valid=%0b addr=%h inst_valid=%0b inst=%h",
               i, bus.imem_req_valid, bus.imem_req_addr, bus.inst_valid, bus.inst_o);
    end

    // Misaligned redirect: state is REQ at 0x8000_0000 after the last vector.
    drive(0, 1, 0, 32'h0, 0, 0, 32'h0);
    drive(0, 0, 1, 32'h0000_0513, 0, 0, 32'h0);
    check_outputs("mis.hold", 1'b0, 1'b1, 32'h8000_0000, 32'h0000_0513, 1'b0);
    drive(0, 0, 0, 32'h0, 1, 1, 32'h8000_0102);
`ifdef YSYX_23060332_IFU_MISALIGN_CHK_EN
    check_outputs("mis.halt", 1'b0, 1'b0, 32'h8000_0000, 32'h0000_0513, 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 1, DB, 1, 1, 32'h8000_0200);
      check_outputs($sformatf("mis.stay%0d", k), 1'b0, 1'b0, 32'h8000_0000,
                    32'h0000_0513, 1'b1);
    end
`else
    check_outputs("mis.redir", 1'b1, 1'b0, 32'h8000_0100, 32'h0000_0513, 1'b0);
    drive(0, 1, 0, 32'h0, 0, 0, 32'h0);
    check_outputs("mis.wait", 1'b0, 1'b0, 32'h8000_0100, 32'h0000_0513, 1'b0);
`endif
    $display("[TB] misaligned redirect: req_valid=%0b pc=%h misalign_err=%0b",
             bus.imem_req_valid, bus.pc_o, bus.misalign_err);

    // Reset clears the sticky state from any point.
    drive(1, 0, 0, 32'h0, 0, 0, 32'h0);
    check_outputs("rst2", 1'b0, 1'b0, 32'h8000_0000, 32'h0, 1'b0);
    drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
    check_outputs("rst2.req", 1'b1, 1'b0, 32'h8000_0000, 32'h0, 1'b0);
    $display("[TB] reset recovery: req_valid=%0b addr=%h", bus.imem_req_valid, bus.imem_req_addr);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
